eth_rx_frame_filter: RTL and testbench

- Controller-clock stage directly downstream of the controller-side RX stream (the rx_contr tvalid/tdata/tlast/tkeep output of the AXIS/controller CDC bridge).
- Parses the Ethernet header, filters frames by destination MAC, drops runts, and truncates oversize frames.
- Forwards accepted frames with an SOF marker and the ethertype to the controller's RX logic.
- The stream carries no backpressure (no tready); the block must accept a beat every cycle.

---
 rtl/eth_rx_frame_filter.sv | 211 +++++++++++++++++++++
 tb/tb_eth_rx_frame_filter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_frame_filter.sv
// rtl/eth_rx_frame_filter.sv - Ethernet RX header parse, destination MAC filter, runt drop and oversize truncation
//
// Sits on the controller clock directly after the RX CDC bridge. The stream has no
// backpressure, so a beat is accepted on every cycle.
//
// Ports:
//   i_ethernet_controller_clk  sole clock
//   i_reset                    asynchronous active-high reset
//   i_rx_t{valid,data,last,keep} input beats, tdata[7:0] = first wire byte
//   i_mac_addr                 station address, [47:40] = wire byte 0
//   i_promisc                  accept every destination address
//   o_rx_t{valid,data,last,keep} forwarded beats
//   o_rx_tuser                 on the tlast beat: 1 = frame truncated at P_MAX_BEATS
//   o_rx_sof                   marks beat 0 of each forwarded frame
//   o_ethertype                ethertype of the most recently accepted frame
//
// Optional: define ETH_RX_FILTER_STATS_EN to add saturating per-frame counters
//   o_cnt_accepted, o_cnt_addr_drop, o_cnt_runt, o_cnt_trunc.

module eth_rx_frame_filter #(
    parameter int P_MAX_BEATS    = 190,
    parameter int P_ACCEPT_MCAST = 1,
    parameter int P_CNT_W        = 32
) (
    input  logic                 i_ethernet_controller_clk,
    input  logic                 i_reset,
    input  logic                 i_rx_tvalid,
    input  logic [63:0]          i_rx_tdata,
    input  logic                 i_rx_tlast,
    input  logic [7:0]           i_rx_tkeep,
    input  logic [47:0]          i_mac_addr,
    input  logic                 i_promisc,
    output logic                 o_rx_tvalid,
    output logic [63:0]          o_rx_tdata,
    output logic                 o_rx_tlast,
    output logic [7:0]           o_rx_tkeep,
    output logic                 o_rx_tuser,
    output logic                 o_rx_sof,
    output logic [15:0]          o_ethertype
`ifdef ETH_RX_FILTER_STATS_EN
    ,
    output logic [P_CNT_W-1:0]   o_cnt_accepted,
    output logic [P_CNT_W-1:0]   o_cnt_addr_drop,
    output logic [P_CNT_W-1:0]   o_cnt_runt,
    output logic [P_CNT_W-1:0]   o_cnt_trunc
`endif
);

    localparam int CNT_W = $clog2(P_MAX_BEATS) + 1;
    localparam logic [CNT_W-1:0] MAX_IDX = CNT_W'(P_MAX_BEATS - 1);
    // Degenerate sizing where beat 1 is already the last permitted beat.
    localparam bit LAST_IS_1 = (P_MAX_BEATS == 2);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_FWD, S_DROP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] beat_cnt;
    logic [63:0]      hold_data;
    logic [7:0]       hold_keep;
    logic             s1_valid, s1_last, s1_user;
    logic [63:0]      s1_data;
    logic [7:0]       s1_keep;

    logic             hold_load, hdr_accept, s1_load, s1_last_nxt, s1_user_nxt, cnt_inc;
    logic             hdr_runt, addr_match;
    logic [47:0]      dst;

    // Wire byte 0 is the MSB byte of i_mac_addr but the LSB byte of tdata.
    always_comb begin
        dst = '0;
        for (int j = 0; j < 6; j++) begin
            dst[47-8*j -: 8] = hold_data[8*j +: 8];
        end
    end

    assign addr_match = i_promisc || (dst == i_mac_addr) || (dst == 48'hFFFF_FFFF_FFFF)
                      || ((P_ACCEPT_MCAST != 0) && hold_data[0]);
    assign hdr_runt   = i_rx_tlast && !i_rx_tkeep[5];

    always_comb begin
        state_nxt   = state;
        hold_load   = 1'b0;
        hdr_accept  = 1'b0;
        s1_load     = 1'b0;
        s1_last_nxt = 1'b0;
        s1_user_nxt = 1'b0;
        cnt_inc     = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_rx_tvalid && !i_rx_tlast) begin
                    hold_load = 1'b1;
                    state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                if (i_rx_tvalid) begin
                    if (hdr_runt) begin
                        state_nxt = S_IDLE;
                    end else if (!addr_match) begin
                        state_nxt = i_rx_tlast ? S_IDLE : S_DROP;
                    end else begin
                        hdr_accept  = 1'b1;
                        s1_load     = 1'b1;
                        s1_last_nxt = i_rx_tlast || LAST_IS_1;
                        s1_user_nxt = !i_rx_tlast && LAST_IS_1;
                        state_nxt   = i_rx_tlast ? S_IDLE : (LAST_IS_1 ? S_DROP : S_FWD);
                    end
                end
            end
            S_FWD: begin
                if (i_rx_tvalid) begin
                    s1_load = 1'b1;
                    if (i_rx_tlast) begin
                        s1_last_nxt = 1'b1;
                        state_nxt   = S_IDLE;
                    end else if (beat_cnt == MAX_IDX) begin
                        s1_last_nxt = 1'b1;
                        s1_user_nxt = 1'b1;
                        state_nxt   = S_DROP;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: begin
                if (i_rx_tvalid && i_rx_tlast) begin
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_ethernet_controller_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= S_IDLE;
            beat_cnt    <= '0;
            hold_data   <= '0;
            hold_keep   <= '0;
            s1_valid    <= 1'b0;
            s1_data     <= '0;
            s1_keep     <= '0;
            s1_last     <= 1'b0;
            s1_user     <= 1'b0;
            o_rx_tvalid <= 1'b0;
            o_rx_tdata  <= '0;
            o_rx_tkeep  <= '0;
            o_rx_tlast  <= 1'b0;
            o_rx_tuser  <= 1'b0;
            o_rx_sof    <= 1'b0;
            o_ethertype <= '0;
        end else begin
            state <= state_nxt;
            if (hold_load) begin
                hold_data <= i_rx_tdata;
                hold_keep <= i_rx_tkeep;
            end
            if (hdr_accept) begin
                beat_cnt    <= CNT_W'(2);
                o_ethertype <= {i_rx_tdata[39:32], i_rx_tdata[47:40]};
            end else if (cnt_inc) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            s1_valid <= s1_load;
            s1_data  <= s1_load ? i_rx_tdata : '0;
            s1_keep  <= s1_load ? i_rx_tkeep : '0;
            s1_last  <= s1_last_nxt;
            s1_user  <= s1_user_nxt;
            // Beat 0 leaves from the hold register the cycle after beat 1 is accepted;
            // s1 is always empty in that cycle because it held nothing from this frame yet.
            if (hdr_accept) begin
                o_rx_tvalid <= 1'b1;
                o_rx_tdata  <= hold_data;
                o_rx_tkeep  <= hold_keep;
                o_rx_tlast  <= 1'b0;
                o_rx_tuser  <= 1'b0;
                o_rx_sof    <= 1'b1;
            end else begin
                o_rx_tvalid <= s1_valid;
                o_rx_tdata  <= s1_data;
                o_rx_tkeep  <= s1_keep;
                o_rx_tlast  <= s1_last;
                o_rx_tuser  <= s1_user;
                o_rx_sof    <= 1'b0;
            end
        end
    end

`ifdef ETH_RX_FILTER_STATS_EN
    logic ev_runt, ev_addr, ev_trunc;

    assign ev_runt  = i_rx_tvalid && i_rx_tlast
                    && ((state == S_IDLE) || ((state == S_HDR) && !i_rx_tkeep[5]));
    assign ev_addr  = i_rx_tvalid && (state == S_HDR) && !hdr_runt && !addr_match;
    assign ev_trunc = s1_load && s1_user_nxt;

    always_ff @(posedge i_ethernet_controller_clk or posedge i_reset) begin
        if (i_reset) begin
            o_cnt_accepted  <= '0;
            o_cnt_addr_drop <= '0;
            o_cnt_runt      <= '0;
            o_cnt_trunc     <= '0;
        end else begin
            if (hdr_accept && (o_cnt_accepted != '1)) o_cnt_accepted <= o_cnt_accepted + 1'b1;
            if (ev_addr && (o_cnt_addr_drop != '1)) o_cnt_addr_drop <= o_cnt_addr_drop + 1'b1;
            if (ev_runt && (o_cnt_runt != '1)) o_cnt_runt <= o_cnt_runt + 1'b1;
            if (ev_trunc && (o_cnt_trunc != '1)) o_cnt_trunc <= o_cnt_trunc + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_eth_rx_frame_filter.sv
// tb/tb_eth_rx_frame_filter.sv - self-checking bench for eth_rx_frame_filter
module tb_eth_rx_frame_filter;

    localparam int          P_MAX = 4;
    localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
    localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] MCAST = 48'h01_00_5E_00_00_01;

    logic        i_ethernet_controller_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_rx_tvalid = 1'b0;
    logic [63:0] i_rx_tdata = '0;
    logic        i_rx_tlast = 1'b0;
    logic [7:0]  i_rx_tkeep = '0;
    logic [47:0] i_mac_addr = MAC;
    logic        i_promisc = 1'b0;
    logic        o_rx_tvalid;
    logic [63:0] o_rx_tdata;
    logic        o_rx_tlast;
    logic [7:0]  o_rx_tkeep;
    logic        o_rx_tuser;
    logic        o_rx_sof;
    logic [15:0] o_ethertype;
`ifdef ETH_RX_FILTER_STATS_EN
    logic [31:0] o_cnt_accepted, o_cnt_addr_drop, o_cnt_runt, o_cnt_trunc;
`endif

    eth_rx_frame_filter #(.P_MAX_BEATS(P_MAX), .P_ACCEPT_MCAST(1), .P_CNT_W(32)) dut (
        .i_ethernet_controller_clk(i_ethernet_controller_clk),
        .i_reset(i_reset),
        .i_rx_tvalid(i_rx_tvalid),
        .i_rx_tdata(i_rx_tdata),
        .i_rx_tlast(i_rx_tlast),
        .i_rx_tkeep(i_rx_tkeep),
        .i_mac_addr(i_mac_addr),
        .i_promisc(i_promisc),
        .o_rx_tvalid(o_rx_tvalid),
        .o_rx_tdata(o_rx_tdata),
        .o_rx_tlast(o_rx_tlast),
        .o_rx_tkeep(o_rx_tkeep),
        .o_rx_tuser(o_rx_tuser),
        .o_rx_sof(o_rx_sof),
        .o_ethertype(o_ethertype)
`ifdef ETH_RX_FILTER_STATS_EN
        ,
        .o_cnt_accepted(o_cnt_accepted),
        .o_cnt_addr_drop(o_cnt_addr_drop),
        .o_cnt_runt(o_cnt_runt),
        .o_cnt_trunc(o_cnt_trunc)
`endif
    );

    always #5 i_ethernet_controller_clk = ~i_ethernet_controller_clk;

    int cyc = 0;
    always @(posedge i_ethernet_controller_clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
        logic        sof;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] exp_etype = '0;

    // Scoreboard monitor: every output beat must match the next expected beat, including its cycle.
    always @(negedge i_ethernet_controller_clk) begin
        if (!i_reset) begin
            n_tests++;
            if (o_rx_tvalid) begin
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat cyc=%0d got data=%h last=%b sof=%b, required no beat",
                             cyc, o_rx_tdata, o_rx_tlast, o_rx_sof);
                end else begin
                    mon_e = sbq.pop_front();
                    if ({o_rx_tdata, o_rx_tkeep, o_rx_tlast, o_rx_tuser, o_rx_sof}
                            !== {mon_e.data, mon_e.keep, mon_e.last, mon_e.user, mon_e.sof}
                            || cyc != mon_e.cyc) begin
                        n_fail++;
                        $display("FAIL out_beat got cyc=%0d data=%h keep=%h last=%b user=%b sof=%b, required cyc=%0d data=%h keep=%h last=%b user=%b sof=%b",
                                 cyc, o_rx_tdata, o_rx_tkeep, o_rx_tlast, o_rx_tuser, o_rx_sof,
                                 mon_e.cyc, mon_e.data, mon_e.keep, mon_e.last, mon_e.user, mon_e.sof);
                    end
                end
            end else if ({o_rx_tdata, o_rx_tkeep, o_rx_tlast, o_rx_tuser, o_rx_sof} !== '0) begin
                n_fail++;
                $display("FAIL idle_zero cyc=%0d got data=%h keep=%h last=%b user=%b sof=%b, required all 0",
                         cyc, o_rx_tdata, o_rx_tkeep, o_rx_tlast, o_rx_tuser, o_rx_sof);
            end
        end
    end

    task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] k, input logic l);
        i_rx_tvalid = v;
        i_rx_tdata  = d;
        i_rx_tkeep  = k;
        i_rx_tlast  = l;
        @(posedge i_ethernet_controller_clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 64'd0, 8'd0, 1'b0);
    endtask

    function automatic logic [63:0] hdr_beat0(input logic [47:0] dst);
        logic [63:0] d;
        d = {$urandom, $urandom};
        for (int j = 0; j < 6; j++) d[8*j +: 8] = dst[47-8*j -: 8];
        return d;
    endfunction

    // Drives one frame; the bench model decides acceptance and pushes the expected beats.
    task automatic send_frame(input int nb, input logic [47:0] dst, input logic [15:0] et,
                              input logic [7:0] lkeep, input int gap);
        logic [63:0] d, b0;
        logic [7:0]  k;
        logic        l;
        bit          acc, done;
        acc  = (nb >= 2) && !(nb == 2 && !lkeep[5])
             && (i_promisc || dst == MAC || dst == BCAST || dst[40]);
        done = 0;
        b0   = '0;
        for (int i = 0; i < nb; i++) begin
            if (i == 2) repeat (gap) idle();
            d = (i == 0) ? hdr_beat0(dst) : {$urandom, $urandom};
            if (i == 1) begin
                d[39:32] = et[15:8];
                d[47:40] = et[7:0];
            end
            l = (i == nb - 1);
            k = l ? lkeep : 8'hFF;
            if (i == 0) b0 = d;
            if (acc && !done && i >= 1) begin
                if (i == 1) begin
                    sbq.push_back('{b0, 8'hFF, 1'b0, 1'b0, 1'b1, cyc + 1});
                    exp_etype = et;
                end
                if (i == P_MAX - 1 && !l) begin
                    sbq.push_back('{d, k, 1'b1, 1'b1, 1'b0, cyc + 2});
                    done = 1;
                end else begin
                    sbq.push_back('{d, k, l, 1'b0, 1'b0, cyc + 2});
                end
            end
            drive(1'b1, d, k, l);
        end
    endtask

    task automatic drain(input string name);
        i_rx_tvalid = 1'b0;
        i_rx_tdata  = '0;
        i_rx_tkeep  = '0;
        i_rx_tlast  = 1'b0;
        for (int i = 0; i < 20 && sbq.size() != 0; i++) begin
            @(posedge i_ethernet_controller_clk);
            #1;
        end
        repeat (3) @(posedge i_ethernet_controller_clk);
        #1;
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing_beats got %0d beats outstanding, required 0", name, sbq.size());
            sbq.delete();
        end
        n_tests++;
        if (o_ethertype !== exp_etype) begin
            n_fail++;
            $display("FAIL %s_ethertype got %h, required %h", name, o_ethertype, exp_etype);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge i_ethernet_controller_clk);
        #1;
        n_tests++;
        if ({o_rx_tvalid, o_rx_tdata, o_rx_tlast, o_rx_tkeep, o_rx_tuser, o_rx_sof, o_ethertype} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got valid=%b data=%h et=%h, required all 0",
                     o_rx_tvalid, o_rx_tdata, o_ethertype);
        end
        i_reset = 1'b0;
        idle();
        n_tests++;
        if (o_rx_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_valid got %b, required 0", o_rx_tvalid);
        end
    endtask

    task automatic test_unicast();
        i_promisc = 1'b0;
        send_frame(3, MAC, 16'h0800, 8'h0F, 0);
        drain("unicast");
    endtask

    task automatic test_addr_filter();
        i_promisc = 1'b0;
        send_frame(3, BCAST, 16'h0806, 8'hFF, 0);
        send_frame(3, OTHER, 16'h0800, 8'hFF, 0);
        send_frame(2, MCAST, 16'h86DD, 8'h3F, 0);
        drain("filter_nopromisc");
        i_promisc = 1'b1;
        send_frame(3, BCAST, 16'h0806, 8'hFF, 0);
        send_frame(3, OTHER, 16'h88B5, 8'hFF, 0);
        drain("filter_promisc");
        i_promisc = 1'b0;
    endtask

    task automatic test_runt();
        send_frame(1, MAC, 16'h1111, 8'hFF, 0);
        send_frame(2, MAC, 16'h2222, 8'h0F, 0);
        send_frame(2, MAC, 16'h3333, 8'h3F, 0);
        drain("runt");
    endtask

    task automatic test_truncate();
        send_frame(7, MAC, 16'h4444, 8'hFF, 0);
        send_frame(3, MAC, 16'h5555, 8'h01, 0);
        send_frame(4, MAC, 16'h6666, 8'h07, 0);
        drain("truncate");
    endtask

    task automatic test_back_to_back();
        send_frame(3, MAC, 16'h7777, 8'hFF, 2);
        send_frame(3, BCAST, 16'h8888, 8'h3F, 1);
        send_frame(2, MAC, 16'h9999, 8'hFF, 0);
        send_frame(2, BCAST, 16'hAAAA, 8'h7F, 0);
        send_frame(4, MAC, 16'hBBBB, 8'h1F, 3);
        drain("back_to_back");
    endtask

    task automatic test_reset_midframe();
        i_promisc = 1'b0;
        drive(1'b1, hdr_beat0(MAC), 8'hFF, 1'b0);
        drive(1'b1, {$urandom, $urandom}, 8'hFF, 1'b0);
        // Beat 2 presented with reset held across its sampling edge.
        i_rx_tdata = {$urandom, $urandom};
        i_reset    = 1'b1;
        exp_etype  = '0;
        #1;
        n_tests++;
        if ({o_rx_tvalid, o_rx_tdata, o_rx_tlast, o_rx_tkeep, o_rx_tuser, o_rx_sof, o_ethertype} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs got valid=%b data=%h sof=%b et=%h, required all 0",
                     o_rx_tvalid, o_rx_tdata, o_rx_sof, o_ethertype);
        end
        @(posedge i_ethernet_controller_clk);
        #1;
        i_reset = 1'b0;
        drive(1'b1, hdr_beat0(OTHER), 8'hFF, 1'b0);
        drive(1'b1, {$urandom, $urandom}, 8'hFF, 1'b1);
        drain("midreset");
`ifdef ETH_RX_FILTER_STATS_EN
        n_tests++;
        if ({o_cnt_accepted, o_cnt_addr_drop, o_cnt_runt, o_cnt_trunc} !== {32'd0, 32'd1, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL midreset_stats got acc=%0d addr=%0d runt=%0d trunc=%0d, required 0 1 0 0",
                     o_cnt_accepted, o_cnt_addr_drop, o_cnt_runt, o_cnt_trunc);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_unicast();
        test_addr_filter();
        test_runt();
        test_truncate();
        test_back_to_back();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
